// File: rtl/obuft_pkg.sv
// Shared types and sizing helpers for the registered tri-state output bank.
package obuft_pkg;

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Guard counter only ever holds TURN_CYC-1 down to 0, so it never wraps.
    function automatic int cnt_width(input int turn_cyc);
        return (turn_cyc < 1) ? 1 : $clog2(turn_cyc + 1);
    endfunction

endpackage

// File: rtl/obuft_chan.sv
// One output channel: turnaround FSM, guard counter, data flops and bufif0-style pad drivers.
module obuft_chan
    import obuft_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gts,
    input  logic             t,
    input  logic [WIDTH-1:0] d,
    output wire  [WIDTH-1:0] pad,
    output logic             drv
);

    localparam int CW = cnt_width(TURN_CYC);
    localparam logic [CW-1:0] CNT_INIT = (TURN_CYC == 0) ? '0 : CW'(TURN_CYC - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic            ts;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: data regs are reset too, so a channel never exposes stale data after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HIZ;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= d;
        end
    end

    // NOTE: defaults first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HIZ: begin
                if (!t && !gts) begin
                    if (TURN_CYC == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = TURN;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            TURN: begin
                if (t || gts) begin
                    state_d = HIZ;
                end else if (cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRIVE: begin
                // Release is immediate: the guard only protects the start of drive.
                if (t || gts) begin
                    state_d = HIZ;
                end
            end
            default: state_d = HIZ;
        endcase
    end

    assign drv = (state_q == DRIVE);

    // GTS acts combinationally on the enables, independent of the clock.
    assign ts  = gts || (state_q != DRIVE);
    assign pad = ts ? {WIDTH{1'bz}} : data_q;

endmodule

// File: rtl/obuft_bank_turn.sv
// Multi-channel registered tri-state output bank with per-channel bus-turnaround guard.
module obuft_bank_turn
    import obuft_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int TURN_CYC = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      GTS,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [CHANNELS-1:0]       T,
    output wire  [CHANNELS*WIDTH-1:0] O,
    output logic [CHANNELS-1:0]       DRV
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        obuft_chan #(
            .WIDTH    (WIDTH),
            .TURN_CYC (TURN_CYC)
        ) u_chan (
            .clk   (CLK),
            .rst_n (RST_N),
            .gts   (GTS),
            .t     (T[c]),
            .d     (I[c*WIDTH +: WIDTH]),
            .pad   (O[c*WIDTH +: WIDTH]),
            .drv   (DRV[c])
        );
    end

endmodule
